johnson_decoder: RTL

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_pkg.sv | 57 +++++
 rtl/johnson_code_check.sv | 24 ++
 rtl/johnson_decoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// Shared types and width-generic helpers for Johnson-code decoding.
// Helpers work on JMAX-bit zero-extended codes with the live width passed in.
package johnson_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } jstate_t;

    localparam int unsigned JMAX = 16;

    function automatic logic [JMAX-1:0] johnson_succ(input logic [JMAX-1:0] c, input int n);
        logic [JMAX-1:0] r;
        r = '0;
        for (int i = 0; i < JMAX - 1; i++) begin
            if (i < n - 1) begin
                r[i] = c[i+1];
            end
        end
        for (int i = 0; i < JMAX; i++) begin
            if (i == n - 1) begin
                r[i] = ~c[0];
            end
        end
        return r;
    endfunction

    // Legal Johnson codes are exactly the words with at most one bit transition.
    function automatic logic johnson_legal(input logic [JMAX-1:0] c, input int n);
        int t;
        t = 0;
        for (int i = 0; i < JMAX - 1; i++) begin
            if ((i < n - 1) && (c[i] != c[i+1])) begin
                t++;
            end
        end
        return (t <= 1);
    endfunction

    function automatic int johnson_index(input logic [JMAX-1:0] c, input int n);
        int pc;
        pc = 0;
        for (int i = 0; i < JMAX; i++) begin
            if ((i < n) && c[i]) begin
                pc++;
            end
        end
        if (pc == 0) begin
            return 0;
        end
        if (c[n-1]) begin
            return pc;
        end
        return 2 * n - pc;
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational check of one sampled code: legality, position decode,
// and comparison against the last legal code (successor / hold).
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  code,
    input  logic [N-1:0]  last,
    output logic          legal,
    output logic [IW-1:0] idx,
    output logic          is_succ,
    output logic          is_hold
);

    always_comb begin
        legal   = johnson_legal(JMAX'(code), N);
        idx     = IW'(johnson_index(JMAX'(code), N));
        is_succ = (johnson_succ(JMAX'(last), N) == JMAX'(code));
        is_hold = (code == last);
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson counter decoder with sequence checking and lock detection.
//   state  | meaning
//   HUNT   | counting consecutive successor steps toward lock
//   LOCKED | sequence trusted; any illegal or out-of-order code drops lock
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int N          = 3,
    parameter int LOCK_CNT   = 4,
    parameter int ALLOW_HOLD = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [N-1:0]              code_in,
    output logic [$clog2(2*N)-1:0]    index,
    output logic                      index_valid,
    output logic                      illegal,
    output logic                      seq_err,
    output logic                      locked,
    output logic [7:0]                err_count
);

    localparam int   IW      = $clog2(2 * N);
    localparam logic HOLD_OK = (ALLOW_HOLD != 0);

    logic          legal;
    logic [IW-1:0] idx_c;
    logic          is_succ;
    logic          is_hold;

    jstate_t       state;
    jstate_t       state_nx;
    logic [3:0]    step_cnt;
    logic [3:0]    step_cnt_nx;
    logic [N-1:0]  last_code;
    logic          have_last;

    logic          ev_illegal;
    logic          ev_seq;
    logic          ev_step;
    logic          ev_err;

    johnson_code_check #(.N(N), .IW(IW)) u_check (
        .code    (code_in),
        .last    (last_code),
        .legal   (legal),
        .idx     (idx_c),
        .is_succ (is_succ),
        .is_hold (is_hold)
    );

    // The first legal code after reset has no predecessor: neither a step nor an error.
    always_comb begin
        ev_illegal = valid_in & ~legal;
        ev_seq     = valid_in & legal & have_last & ~is_succ & ~(HOLD_OK & is_hold);
        ev_step    = valid_in & legal & have_last & is_succ;
        ev_err     = ev_illegal | ev_seq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            step_cnt <= '0;
        end else begin
            state    <= state_nx;
            step_cnt <= step_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        step_cnt_nx = step_cnt;
        case (state)
            HUNT: begin
                if (ev_err) begin
                    step_cnt_nx = '0;
                end else if (ev_step) begin
                    if (step_cnt == 4'(LOCK_CNT - 1)) begin
                        state_nx    = LOCKED;
                        step_cnt_nx = '0;
                    end else begin
                        step_cnt_nx = step_cnt + 4'd1;
                    end
                end
            end
            LOCKED: begin
                step_cnt_nx = '0;
                if (ev_err) begin
                    state_nx = HUNT;
                end
            end
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index       <= '0;
            index_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= '0;
            last_code   <= '0;
            have_last   <= 1'b0;
        end else begin
            index_valid <= valid_in & legal;
            illegal     <= ev_illegal;
            seq_err     <= ev_seq;
            if (valid_in && legal) begin
                index     <= idx_c;
                last_code <= code_in;
                have_last <= 1'b1;
            end
            if (ev_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
